// File: rtl/testdata_check.sv
// Receive-side checker for the memfifo 16-bit test-data pattern: locks onto the 8-word block
// structure and verifies every word and block checksum. Define TESTCHK_CAPTURE_EN to capture the first failing word.
module testdata_check #(
  parameter int LOCK_BLOCKS = 2
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic [15:0] DI,
  input  logic        DI_valid,
  output logic        DI_ready,
  output logic        locked,
  output logic        err_flag,
  output logic [15:0] err_cnt,
  output logic [31:0] word_cnt,
  output logic [7:0]  sync_loss,
  output logic [15:0] exp_word,
  output logic [15:0] got_word
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

  localparam logic [3:0] LockN = 4'(LOCK_BLOCKS);

  state_e      state_q;
  logic        reset_q;
  logic        locked_q;
  logic [6:0]  c_q;
  logic [13:0] cs_q;
  logic [2:0]  k_q;
  logic [3:0]  good_q;
  logic        err_flag_q;
  logic [15:0] err_cnt_q;
  logic [31:0] word_cnt_q;
  logic [7:0]  sync_loss_q;

  logic        accept;
  logic        match;
  logic        last_word;
  logic [6:0]  hi_w;
  logic [6:0]  chk_w;
  logic [13:0] s_w;
  logic [15:0] exp_w;
  logic [6:0]  c_d;
  logic [13:0] cs_d;

  assign DI_ready  = !reset_q;
  assign accept    = DI_valid && DI_ready;
  assign last_word = (k_q == 3'd7);
  assign match     = (DI == exp_w);

  // Expected word and the pattern state that follows it.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hi_w  = c_q + 7'd111;
    s_w   = cs_q + {6'd0, 1'b1, c_q};
    chk_w = s_w[6:0] ^ s_w[13:7];
    exp_w = {1'b1, hi_w, 1'b0, c_q};
    c_d   = c_q + 7'd94;
    cs_d  = cs_q + {6'd0, 1'b1, hi_w} + {7'd0, c_q};
    if (last_word) begin
      exp_w = {1'b1, chk_w, 1'b1, c_q};
      c_d   = c_q + 7'd111;
      cs_d  = 14'd47;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ifclk) begin
    reset_q <= reset;
    if (reset) begin
      state_q     <= HUNT;
      locked_q    <= 1'b0;
      c_q         <= '0;
      cs_q        <= '0;
      k_q         <= '0;
      good_q      <= '0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      sync_loss_q <= '0;
    end else if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (DI[15] && DI[7]) begin
            c_q     <= DI[6:0] + 7'd111;
            cs_q    <= 14'd47;
            k_q     <= '0;
            good_q  <= '0;
            state_q <= SYNC;
          end
        end
        SYNC: begin
          if (!match) begin
            state_q <= HUNT;
          end else begin
            c_q  <= c_d;
            cs_q <= cs_d;
            k_q  <= k_q + 3'd1;
            if (last_word) begin
              good_q <= good_q + 4'd1;
              if (good_q + 4'd1 == LockN) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          word_cnt_q <= word_cnt_q + 32'd1;
          if (!match) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (sync_loss_q != 8'hFF) sync_loss_q <= sync_loss_q + 8'd1;
            err_flag_q <= 1'b1;
            locked_q   <= 1'b0;
            state_q    <= HUNT;
          end else begin
            c_q  <= c_d;
            cs_q <= cs_d;
            k_q  <= k_q + 3'd1;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

`ifdef TESTCHK_CAPTURE_EN
  logic [15:0] exp_word_q;
  logic [15:0] got_word_q;

  // Only the first LOCKED mismatch after reset is kept; err_flag_q marks that it has happened.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      exp_word_q <= '0;
      got_word_q <= '0;
    end else if (accept && state_q == LOCKED && !match && !err_flag_q) begin
      exp_word_q <= exp_w;
      got_word_q <= DI;
    end
  end

  assign exp_word = exp_word_q;
  assign got_word = got_word_q;
`else
  assign exp_word = 16'd0;
  assign got_word = 16'd0;
`endif

  assign locked    = locked_q;
  assign err_flag  = err_flag_q;
  assign err_cnt   = err_cnt_q;
  assign word_cnt  = word_cnt_q;
  assign sync_loss = sync_loss_q;

endmodule

// File: tb/tb_testdata_check.sv
// Directed bench for testdata_check: scenario table over the generator stream plus a
// hand-written reset-while-locked sequence. LOCK_BLOCKS = 2 throughout.
module tb_testdata_check;

  logic        ifclk;
  logic        reset;
  logic [15:0] DI;
  logic        DI_valid;
  logic        DI_ready;
  logic        locked;
  logic        err_flag;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
  logic [7:0]  sync_loss;
  logic [15:0] exp_word;
  logic [15:0] got_word;

  int total = 0;
  int bad   = 0;

  testdata_check #(.LOCK_BLOCKS(2)) dut (
    .ifclk    (ifclk),
    .reset    (reset),
    .DI       (DI),
    .DI_valid (DI_valid),
    .DI_ready (DI_ready),
    .locked   (locked),
    .err_flag (err_flag),
    .err_cnt  (err_cnt),
    .word_cnt (word_cnt),
    .sync_loss(sync_loss),
    .exp_word (exp_word),
    .got_word (got_word)
  );

  initial begin
    ifclk = 1'b0;
    forever #5 ifclk = ~ifclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Generator stream from c = 0, 100 blocks.
  logic [15:0] stream [0:799];

  function automatic void build_stream();
    logic [6:0]  c, hi, chk;
    logic [13:0] cs, s;
    c = 7'd0;
    for (int b = 0; b < 100; b++) begin
      cs = 14'd47;
      for (int k = 0; k < 7; k++) begin
        hi = c + 7'd111;
        stream[b*8+k] = {1'b1, hi, 1'b0, c};
        cs = cs + {6'd0, 1'b1, hi} + {7'd0, c};
        c  = c + 7'd94;
      end
      s   = cs + {6'd0, 1'b1, c};
      chk = s[6:0] ^ s[13:7];
      stream[b*8+7] = {1'b1, chk, 1'b1, c};
      c = c + 7'd111;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // All driving happens at the falling edge; the DUT accepts at the following rising edge.
  task automatic push(input logic [15:0] w);
    int n = 0;
    while (!DI_ready && n < 8) begin
      @(negedge ifclk);
      n++;
    end
    if (!DI_ready) check("ready_timeout", 32'(DI_ready), 32'd1);
    DI       = w;
    DI_valid = 1'b1;
    @(negedge ifclk);
    DI_valid = 1'b0;
  endtask

  task automatic idle();
    DI_valid = 1'b0;
    @(negedge ifclk);
  endtask

  task automatic do_reset();
    @(negedge ifclk);
    reset    = 1'b1;
    DI_valid = 1'b0;
    repeat (2) @(negedge ifclk);
    reset = 1'b0;
    @(negedge ifclk);
  endtask

  typedef struct {
    int skip;
    int nblk;
    int bad_idx;
    int bad_mask;
    int bubbles;
    int lock_idx;
    int err_in_lock;
    int exp_locked;
    int exp_flag;
    int exp_err;
    int exp_sync;
    int exp_wc;
  } vec_t;

  vec_t        vecs [6];
  vec_t        v;
  logic [15:0] w;

  initial begin
    reset    = 1'b1;
    DI       = 16'd0;
    DI_valid = 1'b0;
    build_stream();

    //          skip nblk bad  mask     bub lock inL lck flg err syn wc
    vecs[0] = '{0,   100, -1,  'h0000,  0,  23,  0,  1,  0,  0,  0,  776}; // clean
    vecs[1] = '{3,   20,  -1,  'h0000,  0,  23,  0,  1,  0,  0,  0,  136}; // mid-block start
    vecs[2] = '{0,   20,  42,  'h0001,  0,  23,  1,  1,  1,  1,  1,  115}; // k=2 bit flip
    vecs[3] = '{0,   20,  47,  'h0100,  0,  23,  1,  1,  1,  1,  1,  112}; // checksum flip
    vecs[4] = '{0,   100, -1,  'h0000,  1,  23,  0,  1,  0,  0,  0,  776}; // valid bubbles
    vecs[5] = '{0,   20,  12,  'h0001,  0,  31,  0,  1,  0,  0,  0,  128}; // error during SYNC

    do_reset();
    check("reset_ready",    32'(DI_ready),  32'd1);
    check("reset_locked",   32'(locked),    32'd0);
    check("reset_err_flag", 32'(err_flag),  32'd0);
    check("reset_err_cnt",  32'(err_cnt),   32'd0);
    check("reset_word_cnt", word_cnt,       32'd0);
    check("reset_sync",     32'(sync_loss), 32'd0);
    check("reset_exp_word", 32'(exp_word),  32'd0);
    check("reset_got_word", 32'(got_word),  32'd0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      do_reset();
      for (int n = v.skip; n < v.nblk * 8; n++) begin
        w = stream[n];
        if (n == v.bad_idx) w = w ^ 16'(v.bad_mask);
        if (v.bubbles != 0 && $urandom_range(0, 1) == 1) idle();
        push(w);
        if (n == v.lock_idx - 1) check($sformatf("s%0d locked_before", i), 32'(locked), 32'd0);
        if (n == v.lock_idx)     check($sformatf("s%0d locked_rise", i), 32'(locked), 32'd1);
        if (n == v.bad_idx) begin
          check($sformatf("s%0d err_locked", i), 32'(locked), 32'd0);
          check($sformatf("s%0d err_cnt_now", i), 32'(err_cnt), 32'(v.err_in_lock));
          check($sformatf("s%0d sync_now", i), 32'(sync_loss), 32'(v.err_in_lock));
          check($sformatf("s%0d flag_now", i), 32'(err_flag), 32'(v.err_in_lock));
          if (v.err_in_lock != 0) begin
`ifdef TESTCHK_CAPTURE_EN
            check($sformatf("s%0d exp_word", i), 32'(exp_word), 32'(stream[n]));
            check($sformatf("s%0d got_word", i), 32'(got_word), 32'(stream[n] ^ 16'(v.bad_mask)));
`else
            check($sformatf("s%0d exp_word", i), 32'(exp_word), 32'd0);
            check($sformatf("s%0d got_word", i), 32'(got_word), 32'd0);
`endif
          end else begin
            check($sformatf("s%0d exp_word", i), 32'(exp_word), 32'd0);
          end
        end
      end
      check($sformatf("s%0d locked", i),    32'(locked),    32'(v.exp_locked));
      check($sformatf("s%0d err_flag", i),  32'(err_flag),  32'(v.exp_flag));
      check($sformatf("s%0d err_cnt", i),   32'(err_cnt),   32'(v.exp_err));
      check($sformatf("s%0d sync_loss", i), 32'(sync_loss), 32'(v.exp_sync));
      check($sformatf("s%0d word_cnt", i),  word_cnt,       32'(v.exp_wc));
    end

    // Reset while locked: error at word 30, relock at 47, reset after word 59, relock at 79.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      w = stream[n];
      if (n == 30) w = w ^ 16'h0001;
      push(w);
    end
    check("pre_rst locked",   32'(locked),    32'd1);
    check("pre_rst err_cnt",  32'(err_cnt),   32'd1);
    check("pre_rst sync",     32'(sync_loss), 32'd1);
    check("pre_rst word_cnt", word_cnt,       32'd19);
    reset = 1'b1;
    @(negedge ifclk);
    reset = 1'b0;
    check("rst ready_low",  32'(DI_ready),  32'd0);
    check("rst locked",     32'(locked),    32'd0);
    check("rst err_flag",   32'(err_flag),  32'd0);
    check("rst err_cnt",    32'(err_cnt),   32'd0);
    check("rst sync",       32'(sync_loss), 32'd0);
    check("rst word_cnt",   word_cnt,       32'd0);
    check("rst exp_word",   32'(exp_word),  32'd0);
    check("rst got_word",   32'(got_word),  32'd0);
    @(negedge ifclk);
    check("rst ready_back", 32'(DI_ready),  32'd1);
    for (int n = 60; n < 96; n++) begin
      push(stream[n]);
      if (n == 78) check("post_rst locked_before", 32'(locked), 32'd0);
      if (n == 79) check("post_rst locked_rise",   32'(locked), 32'd1);
    end
    check("post_rst word_cnt", word_cnt,     32'd16);
    check("post_rst err_cnt",  32'(err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
